// File: rtl/rename_reg_file_pkg.sv
// Shared constants and helpers for the rename register file.
// Holds the default sizing parameters and the physical-tag width derivation.
package rename_reg_file_pkg;

    localparam int RRF_NUM_PREGS  = 32;
    localparam int RRF_DATA_W     = 16;
    localparam int RRF_NUM_ALLOC  = 2;
    localparam int RRF_NUM_WB     = 3;
    localparam int RRF_NUM_COMMIT = 2;
    localparam int RRF_NUM_RD     = 7;
    localparam int RRF_AREG_W     = 3;

    // Bits needed to index n entries; never narrower than one bit.
    function automatic int rrf_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rename_reg_file_free_picker.sv
// rrf_free_picker: scans the busy vector from index 0 upward and reports the
// first NUM_ALLOC non-busy entries plus the total number of free entries.
module rrf_free_picker
    import rename_reg_file_pkg::*;
#(
    parameter int NUM_PREGS = RRF_NUM_PREGS,
    parameter int NUM_ALLOC = RRF_NUM_ALLOC,
    parameter int PTAG_W    = rrf_clog2(RRF_NUM_PREGS)
) (
    input  logic [NUM_PREGS-1:0]        busy,
    output logic [NUM_ALLOC*PTAG_W-1:0] pick_tag,
    output logic [PTAG_W:0]             free_cnt
);

    // Priority scan: k-th free entry found lands in pick slot k.
    always_comb begin
        int k;
        k        = 0;
        pick_tag = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            if (!busy[i]) begin
                if (k < NUM_ALLOC) begin
                    pick_tag[k*PTAG_W +: PTAG_W] = PTAG_W'(i);
                end
                k = k + 1;
            end
        end
        free_cnt = (PTAG_W+1)'(k);
    end

endmodule

// File: rtl/rename_reg_file.sv
// rename_reg_file: physical register file with busy/valid tracking for a
// renaming core. Allocation, execute writeback, reads and ROB commit into a
// registered architectural-file write port.
// Optional feature macro: RRF_WB_BYPASS_EN forwards same-cycle writeback data
// to matching read ports.
module rename_reg_file
    import rename_reg_file_pkg::*;
#(
    parameter int NUM_PREGS  = RRF_NUM_PREGS,
    parameter int DATA_W     = RRF_DATA_W,
    parameter int NUM_ALLOC  = RRF_NUM_ALLOC,
    parameter int NUM_WB     = RRF_NUM_WB,
    parameter int NUM_COMMIT = RRF_NUM_COMMIT,
    parameter int NUM_RD     = RRF_NUM_RD,
    parameter int AREG_W     = RRF_AREG_W,
    localparam int PTAG_W    = rrf_clog2(NUM_PREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [NUM_ALLOC-1:0]         alloc_req,
    output logic [NUM_ALLOC-1:0]         alloc_gnt,
    output logic [NUM_ALLOC*PTAG_W-1:0]  alloc_tag,
    output logic [PTAG_W:0]              free_count,
    input  logic [NUM_WB-1:0]            wb_en,
    input  logic [NUM_WB*PTAG_W-1:0]     wb_tag,
    input  logic [NUM_WB*DATA_W-1:0]     wb_data,
    input  logic [NUM_RD*PTAG_W-1:0]     rd_tag,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    input  logic [NUM_COMMIT-1:0]        cm_en,
    input  logic [NUM_COMMIT*PTAG_W-1:0] cm_tag,
    input  logic [NUM_COMMIT*AREG_W-1:0] cm_areg,
    output logic [NUM_COMMIT-1:0]        arf_wr_en,
    output logic [NUM_COMMIT*AREG_W-1:0] arf_wr_idx,
    output logic [NUM_COMMIT*DATA_W-1:0] arf_wr_data
);

    logic [NUM_PREGS-1:0]        ent_busy;
    logic [NUM_PREGS-1:0]        ent_valid;
    logic [DATA_W-1:0]           ent_data [NUM_PREGS];
    logic [NUM_PREGS-1:0]        busy_nxt;
    logic [NUM_PREGS-1:0]        valid_nxt;
    logic [DATA_W-1:0]           data_nxt [NUM_PREGS];
    logic [NUM_PREGS-1:0]        cm_mask;
    logic [NUM_ALLOC*PTAG_W-1:0] pick_tag;
    logic [PTAG_W:0]             free_cnt;

    logic [NUM_COMMIT-1:0]        arf_en_p1;
    logic [NUM_COMMIT*AREG_W-1:0] arf_idx_p1;
    logic [NUM_COMMIT*DATA_W-1:0] arf_data_p1;

    rrf_free_picker #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_ALLOC (NUM_ALLOC),
        .PTAG_W    (PTAG_W)
    ) u_free_picker (
        .busy     (ent_busy),
        .pick_tag (pick_tag),
        .free_cnt (free_cnt)
    );

    assign free_count  = free_cnt;
    assign arf_wr_en   = arf_en_p1;
    assign arf_wr_idx  = arf_idx_p1;
    assign arf_wr_data = arf_data_p1;

    // Grant slots in order; a requesting slot takes the free entry whose rank
    // equals the number of lower requesting slots (the k-th when all request),
    // an idle slot simply shows the k-th free entry.
    always_comb begin
        int pre;
        int rank;
        pre       = 0;
        rank      = 0;
        alloc_gnt = '0;
        alloc_tag = '0;
        for (int k = 0; k < NUM_ALLOC; k++) begin
            rank         = alloc_req[k] ? pre : k;
            alloc_gnt[k] = alloc_req[k] & ~stall & ~flush & (int'(free_cnt) > pre);
            alloc_tag[k*PTAG_W +: PTAG_W] = pick_tag[rank*PTAG_W +: PTAG_W];
            if (alloc_req[k]) begin
                pre = pre + 1;
            end
        end
    end

    // Next entry state: writeback (highest port last), commit overrides
    // writeback, then fresh allocations of entries that were free.
    always_comb begin
        logic [PTAG_W-1:0] t;
        t         = '0;
        cm_mask   = '0;
        busy_nxt  = ent_busy;
        valid_nxt = ent_valid;
        data_nxt  = ent_data;
        for (int c = 0; c < NUM_COMMIT; c++) begin
            if (cm_en[c]) begin
                cm_mask[cm_tag[c*PTAG_W +: PTAG_W]] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_WB; i++) begin
            t = wb_tag[i*PTAG_W +: PTAG_W];
            if (wb_en[i] && ent_busy[t] && !cm_mask[t]) begin
                data_nxt[t]  = wb_data[i*DATA_W +: DATA_W];
                valid_nxt[t] = 1'b1;
            end
        end
        for (int c = 0; c < NUM_COMMIT; c++) begin
            t = cm_tag[c*PTAG_W +: PTAG_W];
            if (cm_en[c]) begin
                busy_nxt[t]  = 1'b0;
                valid_nxt[t] = 1'b0;
            end
        end
        for (int k = 0; k < NUM_ALLOC; k++) begin
            t = alloc_tag[k*PTAG_W +: PTAG_W];
            if (alloc_gnt[k]) begin
                busy_nxt[t]  = 1'b1;
                valid_nxt[t] = 1'b0;
            end
        end
    end

    // Entry state and ARF write stage (p1): rst > flush > stall > update.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_busy    <= '0;
            ent_valid   <= '0;
            for (int i = 0; i < NUM_PREGS; i++) begin
                ent_data[i] <= '0;
            end
            arf_en_p1   <= '0;
            arf_idx_p1  <= '0;
            arf_data_p1 <= '0;
        end else if (flush) begin
            ent_busy  <= '0;
            ent_valid <= '0;
            arf_en_p1 <= '0;
        end else if (!stall) begin
            ent_busy  <= busy_nxt;
            ent_valid <= valid_nxt;
            ent_data  <= data_nxt;
            for (int c = 0; c < NUM_COMMIT; c++) begin
                arf_en_p1[c] <= cm_en[c];
                if (cm_en[c]) begin
                    arf_idx_p1[c*AREG_W +: AREG_W]  <= cm_areg[c*AREG_W +: AREG_W];
                    arf_data_p1[c*DATA_W +: DATA_W] <= ent_data[cm_tag[c*PTAG_W +: PTAG_W]];
                end
            end
        end
    end

    // Combinational read ports, optionally forwarding in-flight writeback.
    always_comb begin
        logic [PTAG_W-1:0] t;
        t        = '0;
        rd_data  = '0;
        rd_valid = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            t = rd_tag[r*PTAG_W +: PTAG_W];
            rd_data[r*DATA_W +: DATA_W] = ent_data[t];
            rd_valid[r]                 = ent_valid[t];
`ifdef RRF_WB_BYPASS_EN
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_en[i] && (wb_tag[i*PTAG_W +: PTAG_W] == t) && ent_busy[t]) begin
                    rd_data[r*DATA_W +: DATA_W] = wb_data[i*DATA_W +: DATA_W];
                    rd_valid[r]                 = 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file (default parameters).
// Commit results are predicted into a scoreboard queue when the commit is
// driven and compared when the ARF write port presents them.
module tb_rename_reg_file;

    localparam int NP = 32;
    localparam int DW = 16;
    localparam int NA = 2;
    localparam int NW = 3;
    localparam int NC = 2;
    localparam int NR = 7;
    localparam int AW = 3;
    localparam int TW = 5;

    logic              clk = 1'b0;
    logic              rst, stall, flush;
    logic [NA-1:0]     alloc_req, alloc_gnt;
    logic [NA*TW-1:0]  alloc_tag;
    logic [TW:0]       free_count;
    logic [NW-1:0]     wb_en;
    logic [NW*TW-1:0]  wb_tag;
    logic [NW*DW-1:0]  wb_data;
    logic [NR*TW-1:0]  rd_tag;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_valid;
    logic [NC-1:0]     cm_en;
    logic [NC*TW-1:0]  cm_tag;
    logic [NC*AW-1:0]  cm_areg;
    logic [NC-1:0]     arf_wr_en;
    logic [NC*AW-1:0]  arf_wr_idx;
    logic [NC*DW-1:0]  arf_wr_data;

    typedef struct {
        int          port;
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } cm_exp_t;

    cm_exp_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    rename_reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_tag   (alloc_tag),
        .free_count  (free_count),
        .wb_en       (wb_en),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .cm_en       (cm_en),
        .cm_tag      (cm_tag),
        .cm_areg     (cm_areg),
        .arf_wr_en   (arf_wr_en),
        .arf_wr_idx  (arf_wr_idx),
        .arf_wr_data (arf_wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; alloc_req = '0;
        wb_en = '0; wb_tag = '0; wb_data = '0;
        cm_en = '0; cm_tag = '0; cm_areg = '0;
    endtask

    task automatic drive_wb(input int p, input int tag, input logic [DW-1:0] d);
        wb_en[p] = 1'b1;
        wb_tag[p*TW +: TW] = TW'(tag);
        wb_data[p*DW +: DW] = d;
    endtask

    task automatic drive_cm(input int p, input int tag, input int areg, input logic [DW-1:0] exp_data);
        cm_exp_t e;
        cm_en[p] = 1'b1;
        cm_tag[p*TW +: TW] = TW'(tag);
        cm_areg[p*AW +: AW] = AW'(areg);
        e.port = p; e.idx = AW'(areg); e.data = exp_data;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        cm_exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk("arf_en", 64'(arf_wr_en[e.port]), 64'd1);
            chk("arf_idx", 64'(arf_wr_idx[e.port*AW +: AW]), 64'(e.idx));
            chk("arf_data", 64'(arf_wr_data[e.port*DW +: DW]), 64'(e.data));
        end
    endtask

    task automatic set_rd(input int p, input int tag);
        rd_tag[p*TW +: TW] = TW'(tag);
    endtask

    initial begin
        idle_inputs();
        rd_tag = '0;
        rst = 1;
        step(); step();
        rst = 0;
        #1;
        // reset state
        chk("rst_free", 64'(free_count), 64'd32);
        chk("rst_tag0", 64'(alloc_tag[0 +: TW]), 64'd0);
        chk("rst_tag1", 64'(alloc_tag[TW +: TW]), 64'd1);
        chk("rst_arf_en", 64'(arf_wr_en), 64'd0);
        chk("rst_arf_idx", 64'(arf_wr_idx), 64'd0);
        chk("rst_arf_data", 64'(arf_wr_data), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);

        // first dual allocation
        alloc_req = 2'b11; #1;
        chk("a_gnt", 64'(alloc_gnt), 64'b11);
        chk("a_tag0", 64'(alloc_tag[0 +: TW]), 64'd0);
        chk("a_tag1", 64'(alloc_tag[TW +: TW]), 64'd1);
        step();
        alloc_req = '0; #1;
        chk("a_free30", 64'(free_count), 64'd30);

        // fill to 31 busy, then the last entry
        for (int i = 0; i < 14; i++) begin
            alloc_req = 2'b11; step();
        end
        alloc_req = 2'b01; step();
        alloc_req = 2'b11; #1;
        chk("b_free1", 64'(free_count), 64'd1);
        chk("b_gnt01", 64'(alloc_gnt), 64'b01);
        chk("b_tag31", 64'(alloc_tag[0 +: TW]), 64'd31);
        step(); #1;
        chk("b_gnt00", 64'(alloc_gnt), 64'b00);
        chk("b_free0", 64'(free_count), 64'd0);
        alloc_req = '0;

        // writeback then commit
        drive_wb(0, 5, 16'hBEEF);
        step();
        idle_inputs();
        set_rd(0, 5); #1;
        chk("c_rd_valid", 64'(rd_valid[0]), 64'd1);
        chk("c_rd_data", 64'(rd_data[0 +: DW]), 64'hBEEF);
        drive_cm(0, 5, 3, 16'hBEEF);
        step();
        idle_inputs(); #1;
        sb_check();
        chk("c_free1", 64'(free_count), 64'd1);
        chk("c_tag5", 64'(alloc_tag[0 +: TW]), 64'd5);

        // two writeback ports to one tag, highest port wins
        drive_wb(0, 4, 16'h1111);
        drive_wb(2, 4, 16'h2222);
        step();
        idle_inputs();
        set_rd(1, 4); #1;
        chk("d_rd_data", 64'(rd_data[DW +: DW]), 64'h2222);
        chk("d_rd_valid", 64'(rd_valid[1]), 64'd1);
        // commit and writeback collide on tag 4: commit frees it
        drive_cm(0, 4, 1, 16'h2222);
        drive_wb(1, 4, 16'h3333);
        step();
        idle_inputs(); #1;
        sb_check();
        chk("d_free2", 64'(free_count), 64'd2);
        chk("d_rd4_invalid", 64'(rd_valid[1]), 64'd0);

        // reallocate 4 and 5, then commit never-written entry 5 (stale data)
        alloc_req = 2'b11; #1;
        chk("e_gnt", 64'(alloc_gnt), 64'b11);
        chk("e_tag0", 64'(alloc_tag[0 +: TW]), 64'd4);
        chk("e_tag1", 64'(alloc_tag[TW +: TW]), 64'd5);
        step();
        idle_inputs();
        drive_cm(1, 5, 6, 16'hBEEF);
        step();
        idle_inputs();

        // stall with everything active
        stall = 1; alloc_req = 2'b11;
        drive_wb(0, 10, 16'h5555);
        cm_en[0] = 1'b1; cm_tag[0 +: TW] = TW'(11); cm_areg[0 +: AW] = AW'(2);
        set_rd(1, 10); #1;
        chk("s_gnt", 64'(alloc_gnt), 64'd0);
        sb_check();
        chk("s_arf_en_pre", 64'(arf_wr_en), 64'b10);
        step();
        chk("s_free_hold", 64'(free_count), 64'd1);
        chk("s_rd10_invalid", 64'(rd_valid[1]), 64'd0);
        chk("s_arf_en_hold", 64'(arf_wr_en), 64'b10);
        chk("s_arf_idx_hold", 64'(arf_wr_idx[AW +: AW]), 64'd6);

        // flush overrides stall
        flush = 1; #1;
        chk("f_gnt", 64'(alloc_gnt), 64'd0);
        step();
        idle_inputs(); #1;
        chk("f_free32", 64'(free_count), 64'd32);
        chk("f_arf_en", 64'(arf_wr_en), 64'd0);

        // writeback to a free entry is dropped
        drive_wb(0, 20, 16'h1234);
        step();
        idle_inputs();
        set_rd(2, 20); #1;
        chk("g_rd20_valid", 64'(rd_valid[2]), 64'd0);
        chk("g_rd20_data", 64'(rd_data[2*DW +: DW]), 64'd0);

        // allocate 0..7, then read tag 7 during its writeback
        for (int i = 0; i < 4; i++) begin
            alloc_req = 2'b11; step();
        end
        alloc_req = '0; #1;
        chk("h_free24", 64'(free_count), 64'd24);
        set_rd(3, 7);
        drive_wb(0, 7, 16'h0055);
        drive_wb(1, 7, 16'h00AA); #1;
`ifdef RRF_WB_BYPASS_EN
        chk("h_byp_valid", 64'(rd_valid[3]), 64'd1);
        chk("h_byp_data", 64'(rd_data[3*DW +: DW]), 64'h00AA);
`else
        chk("h_nobyp_valid", 64'(rd_valid[3]), 64'd0);
`endif
        step();
        idle_inputs(); #1;
        chk("h_rd7_valid", 64'(rd_valid[3]), 64'd1);
        chk("h_rd7_data", 64'(rd_data[3*DW +: DW]), 64'h00AA);

        // reset mid-operation discards grants and commits
        alloc_req = 2'b11;
        cm_en[0] = 1'b1; cm_tag[0 +: TW] = TW'(7); cm_areg[0 +: AW] = AW'(5);
        rst = 1;
        step();
        rst = 0;
        idle_inputs(); #1;
        chk("r_free32", 64'(free_count), 64'd32);
        chk("r_arf_en", 64'(arf_wr_en), 64'd0);
        chk("r_rd7_valid", 64'(rd_valid[3]), 64'd0);
        chk("r_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
